// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types for the execute/memory boundary.
package mips_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEM_REQ = 1'b1
  } state_e;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned ALIGN_BITS          = 2;
  localparam int unsigned WORD_ADDR_W         = XLEN - ALIGN_BITS;
  localparam int unsigned REG_ADDR_W          = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = 5'd0;
  localparam int unsigned DEFAULT_ACK_TIMEOUT = 255;

endpackage

// File: rtl/ack_timer.sv
// Loadable up-counter with clear and a terminal-count flag, used to bound memory ack waits.
module ack_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TERMINAL = 254
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic             tc_c
);

  logic [WIDTH-1:0] count_q, count_d;

  // Clear dominates load, load dominates increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: registers the ALU bundle, resolves branches, runs the data-memory
// req/ack access and emits exactly one write-back record per accepted bundle.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        alu_out,
  input  logic [XLEN-1:0]        write_data,
  input  logic [REG_ADDR_W-1:0]  write_reg_addr,
  input  logic [XLEN-1:0]        pc_branch,
  input  logic                   zero,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   reg_write,
  input  logic                   branch_eq,
  input  logic                   branch_ne,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [WORD_ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]        dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [XLEN-1:0]        dmem_rdata,
  output logic                   branch_taken,
  output logic [XLEN-1:0]        branch_target,
  output logic                   wb_valid,
  output logic                   wb_reg_write,
  output logic [REG_ADDR_W-1:0]  wb_reg_addr,
  output logic [XLEN-1:0]        wb_data,
  output logic                   mem_fault
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    dmem_req_q, dmem_req_d;
  logic                    dmem_we_q, dmem_we_d;
  logic [WORD_ADDR_W-1:0]  dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]         dmem_wdata_q, dmem_wdata_d;
  logic [REG_ADDR_W-1:0]   mem_dest_q, mem_dest_d;
  logic                    mem_rw_q, mem_rw_d;
  logic                    wb_valid_q, wb_valid_d;
  logic                    wb_reg_write_q, wb_reg_write_d;
  logic [REG_ADDR_W-1:0]   wb_reg_addr_q, wb_reg_addr_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d;
  logic                    mem_fault_q, mem_fault_d;
  logic                    branch_taken_q, branch_taken_d;
  logic [XLEN-1:0]         branch_target_q, branch_target_d;

  logic xfer, is_mem, is_branch, misaligned, br_cond;
  logic tmr_clr, tmr_load, tmr_inc, tmr_tc;

  assign xfer       = in_valid & in_ready_q;
  assign is_mem     = mem_read | mem_write;
  assign is_branch  = branch_eq | branch_ne;
  assign misaligned = |alu_out[ALIGN_BITS-1:0];
  assign br_cond    = (branch_eq & zero) | (branch_ne & ~zero);

  ack_timer #(
    .WIDTH    (CNT_W),
    .TERMINAL (ACK_TIMEOUT - 1)
  ) u_ack_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (CNT_W'(0)),
    .inc      (tmr_inc),
    .tc_c     (tmr_tc)
  );

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d         = state_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wdata_d    = dmem_wdata_q;
    mem_dest_d      = mem_dest_q;
    mem_rw_d        = mem_rw_q;
    wb_valid_d      = 1'b0;
    wb_reg_write_d  = 1'b0;
    wb_reg_addr_d   = wb_reg_addr_q;
    wb_data_d       = wb_data_q;
    mem_fault_d     = 1'b0;
    branch_taken_d  = 1'b0;
    branch_target_d = '0;
    tmr_clr         = 1'b0;
    tmr_load        = 1'b0;
    tmr_inc         = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          branch_taken_d  = br_cond;
          branch_target_d = br_cond ? pc_branch : '0;
          if (is_mem && !misaligned) begin
            // mem_read wins when both read and write are set.
            state_d      = MEM_REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write & ~mem_read;
            dmem_addr_d  = alu_out[XLEN-1:ALIGN_BITS];
            dmem_wdata_d = write_data;
            mem_dest_d   = write_reg_addr;
            mem_rw_d     = mem_read & reg_write;
            tmr_load     = 1'b1;
          end else begin
            wb_valid_d     = 1'b1;
            wb_reg_addr_d  = write_reg_addr;
            wb_data_d      = alu_out;
            wb_reg_write_d = reg_write & ~is_mem & ~is_branch &
                             (write_reg_addr != REG_ZERO);
            mem_fault_d    = is_mem;
          end
        end
      end
      MEM_REQ: begin
        if (dmem_ack) begin
          // An ack on the terminal cycle still completes the access.
          state_d        = IDLE;
          dmem_req_d     = 1'b0;
          wb_valid_d     = 1'b1;
          wb_reg_addr_d  = mem_dest_q;
          wb_reg_write_d = mem_rw_q & (mem_dest_q != REG_ZERO);
          if (!dmem_we_q) begin
            wb_data_d = dmem_rdata;
          end
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          state_d       = IDLE;
          dmem_req_d    = 1'b0;
          wb_valid_d    = 1'b1;
          wb_reg_addr_d = mem_dest_q;
          mem_fault_d   = 1'b1;
          tmr_clr       = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
        tmr_clr    = 1'b1;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      in_ready_q      <= 1'b1;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      mem_dest_q      <= '0;
      mem_rw_q        <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_reg_addr_q   <= '0;
      wb_data_q       <= '0;
      mem_fault_q     <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      state_q         <= state_d;
      in_ready_q      <= in_ready_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wdata_q    <= dmem_wdata_d;
      mem_dest_q      <= mem_dest_d;
      mem_rw_q        <= mem_rw_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_reg_addr_q   <= wb_reg_addr_d;
      wb_data_q       <= wb_data_d;
      mem_fault_q     <= mem_fault_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_reg_addr   = wb_reg_addr_q;
  assign wb_data       = wb_data_q;
  assign mem_fault     = mem_fault_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;

  // Upstream must never issue read+write together or a branch with a memory op.
  illegal_ctrl_a: assert property (@(posedge clk) disable iff (reset)
    xfer |-> (!(mem_read && mem_write) && !(is_branch && is_mem)));

endmodule
